regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Shares the single write port of the 16 x 16-bit register file between two independent write requesters: A (ALU writeback) and B (load / PC-link writeback). Each requester has a one-entry input buffer behind a valid/ready handshake. A round-robin arbiter drains one buffer per cycle into registered write-port outputs (rf_wen / rf_waddr / rf_wdata), which drive the register file's wen/address/data inputs directly.

Parameters:
DW, 16, data width of a register-file write
AW, 4, register address width (2**AW registers)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
a_valid  input  1  requester A write request
a_ready  output  1  A buffer empty; A request accepted when a_valid & a_ready
a_addr  input  AW  A destination register
a_data  input  DW  A write data
b_valid  input  1  requester B write request
b_ready  output  1  B buffer empty
b_addr  input  AW  B destination register
b_data  input  DW  B write data
rf_wen  output  1  register-file write enable (registered)
rf_waddr  output  AW  register-file write address (registered)
rf_wdata  output  DW  register-file write data (registered)
busy  output  1  either buffer full or rf_wen high

Behaviour:
- Reset (synchronous, active-high, sampled at posedge): both buffers empty; a_ready = b_ready = 1 in the next cycle; rf_wen = 0, rf_waddr = 0, rf_wdata = 0; priority pointer = A; busy = 0. rst has precedence over every other event. Buffered, unwritten requests are discarded. A write already presented on rf_wen during the reset cycle still completes at that edge.
- Ready generation:
  - a_ready = ~a_full and b_ready = ~b_full, taken straight from flops. No combinational path from valid to ready.
  - A buffer that drains at an edge is empty, and its ready is high, in the following cycle.
- Accept: at a posedge with x_valid & x_ready, x_addr/x_data are captured and x_full is set. When x_ready = 0, x_valid is ignored; the requester must hold its request.
- Arbitration is evaluated each cycle on buffer state only:
  - Neither buffer full: no grant; rf_wen = 0 next cycle; rf_waddr/rf_wdata hold their previous values.
  - Exactly one buffer full: that buffer wins.
  - Both full: the pointer decides the winner.
  - Winner effect at the posedge: its entry loads into rf_waddr/rf_wdata, rf_wen = 1 for one cycle, its full flag clears, and the pointer moves to the other requester.
  - Pointer changes only on a grant.
- Latency: accept at edge N, then rf_wen high in the cycle after edge N+1, i.e. the write commits at edge N+2. A lone requester sustains one write per 2 cycles; both requesters together sustain one write per cycle.
- Same-address conflict (both full, equal addr): both are written in pointer order, so the later grant's data is final. Requesters own ordering; the arbiter does no coalescing or reordering.
- Accept and drain on the same buffer in the same cycle is impossible, because ready is low while full.
- Simultaneous A and B accept in one cycle is legal; both buffers fill.
- The address has no wrap-around; all 2**AW addresses are legal.
- busy = a_full | b_full | rf_wen, registered-equivalent (built from flops only).

Optional Feature:
Macro RF_ZERO_DROP_EN.
- Defined: a request with addr == 0 completes its handshake (x_ready stays 1) but is never loaded into the buffer, never granted and never drives rf_wen. The pointer is unaffected. This enforces the hard-zero R0 rule.
- Not defined: address 0 is handled exactly like any other address.

Test Plan:
1. Reset, then idle 5 cycles -> rf_wen = 0, rf_waddr = 0, rf_wdata = 0, a_ready = b_ready = 1, busy = 0 throughout.
2. Single A write: a_valid with addr 3, data 0x1234, for one cycle -> a_ready = 0 next cycle; rf_wen = 1 with waddr 3, wdata 0x1234 exactly 2 cycles after accept; a_ready = 1 in that same cycle.
3. Simultaneous A (addr 5, 0xAAAA) and B (addr 6, 0xBBBB) after reset -> A written first, then B on the next consecutive cycle. Repeat with A (7, 0x0007) and B (8, 0x0008) -> pointer order gives A then B again, because the pointer returned to A after B's grant.
4. Same-address conflict: both full at addr 9, A data 0x0001, B data 0x0002, pointer = B -> writes 0x0002 then 0x0001 on consecutive cycles; register 9 ends at 0x0001.
5. Reset mid-operation: both buffers full, assert rst for one cycle -> no further rf_wen pulses; both readys = 1 and busy = 0 the cycle after reset. A subsequent B request to addr 2 is written with normal 2-cycle latency.
6. With RF_ZERO_DROP_EN defined: A request with addr 0, data 0xFFFF -> handshake completes, a_ready stays 1, rf_wen never asserts. Without the macro: the same stimulus -> rf_wen = 1 with waddr 0, wdata 0xFFFF after 2 cycles.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Write-request bus for regfile_wr_arbiter.
//   Requester A / B : x_valid, x_addr, x_data in; x_ready out.
//   Register file   : rf_wen, rf_waddr, rf_wdata (registered, from the arbiter).
//   Status          : busy (either buffer holds an entry or a write is on rf_wen).
// Handshake: a request transfers at a posedge where x_valid & x_ready are both 1.
// A requester whose request is not taken must hold x_valid/x_addr/x_data stable.
// x_ready comes straight from a flop and never depends on x_valid.
interface regfile_wr_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;

  // Requesters plus register-file side (bench or surrounding core).
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_wen, rf_waddr, rf_wdata, busy
  );

  // The arbiter itself.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_wen, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single register-file write port between
// requester A (ALU writeback) and requester B (load / PC-link writeback).
// Each requester has a one-entry buffer; a round-robin arbiter drains one
// buffer per cycle into the registered write-port outputs.
//
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - regfile_wr_arbiter_if.slave (A/B requests, rf_* write port, busy)
//
// Optional feature (macro RF_ZERO_DROP_EN): when defined, a request to
// address 0 completes its handshake but is discarded (R0 is hard zero).
module regfile_wr_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);

  logic          a_full, b_full;
  logic [AW-1:0] a_addr_q, b_addr_q;
  logic [DW-1:0] a_data_q, b_data_q;
  // Round-robin pointer: 0 = A wins a tie, 1 = B wins a tie.
  logic          ptr_b;
  logic          rf_wen_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;

  logic a_acc, b_acc, a_load, b_load, grant_a, grant_b;

  always_comb begin
    a_acc   = bus.a_valid & ~a_full;
    b_acc   = bus.b_valid & ~b_full;
`ifdef RF_ZERO_DROP_EN
    // Handshake still completes; the entry just never enters the buffer.
    a_load  = a_acc & (bus.a_addr != '0);
    b_load  = b_acc & (bus.b_addr != '0);
`else
    a_load  = a_acc;
    b_load  = b_acc;
`endif
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && b_full) begin
      grant_a = ~ptr_b;
      grant_b = ptr_b;
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full     <= 1'b0;
      b_full     <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      ptr_b      <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q <= grant_a | grant_b;
      if (grant_a) begin
        rf_waddr_q <= a_addr_q;
        rf_wdata_q <= a_data_q;
        ptr_b      <= 1'b1;
      end else if (grant_b) begin
        rf_waddr_q <= b_addr_q;
        rf_wdata_q <= b_data_q;
        ptr_b      <= 1'b0;
      end

      // A full buffer has ready low, so load and drain never coincide.
      if (grant_a) begin
        a_full <= 1'b0;
      end else if (a_load) begin
        a_full   <= 1'b1;
        a_addr_q <= bus.a_addr;
        a_data_q <= bus.a_data;
      end

      if (grant_b) begin
        b_full <= 1'b0;
      end else if (b_load) begin
        b_full   <= 1'b1;
        b_addr_q <= bus.b_addr;
        b_data_q <= bus.b_data;
      end
    end
  end

  assign bus.a_ready  = ~a_full;
  assign bus.b_ready  = ~b_full;
  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = a_full | b_full | rf_wen_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_wr_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_data = data;
  endtask

  task automatic drive_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_data = data;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.rf_wen); end
      checks++; if (bus.rf_waddr !== 4'h0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", bus.rf_wdata); end
      checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b exp=1", bus.a_ready); end
      checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL reset_b_ready got=%b exp=1", bus.b_ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    end
  endtask

  task automatic test_single_a();
    do_reset();
    drive_a(4'd3, 16'h1234);
    tick();
    bus.a_valid = 1'b0;
    checks++; if (bus.a_ready !== 1'b0) begin failures++; $display("FAIL single_a_ready_low got=%b exp=0", bus.a_ready); end
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL single_wen_early got=%b exp=0", bus.rf_wen); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    tick();
    checks++; if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL single_wen got=%b exp=1", bus.rf_wen); end
    checks++; if (bus.rf_waddr !== 4'd3) begin failures++; $display("FAIL single_waddr got=%h exp=3", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 16'h1234) begin failures++; $display("FAIL single_wdata got=%h exp=1234", bus.rf_wdata); end
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL single_a_ready_back got=%b exp=1", bus.a_ready); end
    tick();
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL single_wen_pulse got=%b exp=0", bus.rf_wen); end
    checks++; if (bus.rf_waddr !== 4'd3) begin failures++; $display("FAIL single_waddr_hold got=%h exp=3", bus.rf_waddr); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", bus.busy); end
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    ea[0] = 4'd5; ed[0] = 16'hAAAA;
    ea[1] = 4'd6; ed[1] = 16'hBBBB;
    ea[2] = 4'd7; ed[2] = 16'h0007;
    ea[3] = 4'd8; ed[3] = 16'h0008;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      drive_a(ea[2*r], ed[2*r]);
      drive_b(ea[2*r+1], ed[2*r+1]);
      tick();
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
        tick();
        checks++; if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL simul_wen r%0d k%0d got=%b exp=1", r, k, bus.rf_wen); end
        checks++; if (bus.rf_waddr !== ea[2*r+k]) begin failures++; $display("FAIL simul_waddr r%0d k%0d got=%h exp=%h", r, k, bus.rf_waddr, ea[2*r+k]); end
        checks++; if (bus.rf_wdata !== ed[2*r+k]) begin failures++; $display("FAIL simul_wdata r%0d k%0d got=%h exp=%h", r, k, bus.rf_wdata, ed[2*r+k]); end
      end
      tick();
      checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL simul_wen_end r%0d got=%b exp=0", r, bus.rf_wen); end
    end
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] last9;
    last9 = '0;
    do_reset();
    // One A write first so the pointer sits on B.
    drive_a(4'd1, 16'h5555);
    tick();
    idle_inputs();
    tick();
    tick();
    drive_a(4'd9, 16'h0001);
    drive_b(4'd9, 16'h0002);
    tick();
    idle_inputs();
    tick();
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 4'd9 || bus.rf_wdata !== 16'h0002) begin
      failures++; $display("FAIL same_addr_first got=%b/%h/%h exp=1/9/0002", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
    if (bus.rf_wen === 1'b1 && bus.rf_waddr === 4'd9) last9 = bus.rf_wdata;
    tick();
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 4'd9 || bus.rf_wdata !== 16'h0001) begin
      failures++; $display("FAIL same_addr_second got=%b/%h/%h exp=1/9/0001", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
    if (bus.rf_wen === 1'b1 && bus.rf_waddr === 4'd9) last9 = bus.rf_wdata;
    checks++; if (last9 !== 16'h0001) begin failures++; $display("FAIL same_addr_final got=%h exp=0001", last9); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_a(4'd10, 16'hA10A);
    drive_b(4'd11, 16'hB11B);
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL rstmid_a_ready got=%b exp=1", bus.a_ready); end
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL rstmid_b_ready got=%b exp=1", bus.b_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL rstmid_wen got=%b exp=0", bus.rf_wen); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL rstmid_no_write c%0d got=%b exp=0", i, bus.rf_wen); end
    end
    drive_b(4'd2, 16'h2222);
    tick();
    idle_inputs();
    checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("FAIL rstmid_b_accept got=%b exp=0", bus.b_ready); end
    tick();
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 4'd2 || bus.rf_wdata !== 16'h2222) begin
      failures++; $display("FAIL rstmid_b_write got=%b/%h/%h exp=1/2/2222", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_zero_addr();
    do_reset();
    drive_a(4'd0, 16'hFFFF);
    tick();
    idle_inputs();
`ifdef RF_ZERO_DROP_EN
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL zero_drop_ready got=%b exp=1", bus.a_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL zero_drop_wen c%0d got=%b exp=0", i, bus.rf_wen); end
    end
`else
    checks++; if (bus.a_ready !== 1'b0) begin failures++; $display("FAIL zero_ready got=%b exp=0", bus.a_ready); end
    tick();
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 4'd0 || bus.rf_wdata !== 16'hFFFF) begin
      failures++; $display("FAIL zero_write got=%b/%h/%h exp=1/0/ffff", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
`endif
  endtask

  // Randomised traffic against a transaction-level model: each requester
  // owns a pending queue of depth one; each cycle the model picks a winner
  // by the round-robin rule and pushes the write into exp_q.
  task automatic test_random();
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] a_pend[$];
    logic [AW+DW-1:0] b_pend[$];
    logic [AW+DW-1:0] e;
    logic [AW+DW-1:0] got;
    bit               prefer_a;
    bit               m_wen;
    logic [AW-1:0]    m_waddr;
    logic [DW-1:0]    m_wdata;
    bit               a_wait, b_wait, a_acc, b_acc, zero_drop;
    int               winner;
`ifdef RF_ZERO_DROP_EN
    zero_drop = 1'b1;
`else
    zero_drop = 1'b0;
`endif
    do_reset();
    prefer_a = 1'b1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    a_wait = 1'b0; b_wait = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // compare outputs produced by the edge just passed
      if (cyc % 4 == 0 || m_wen) begin
        checks++; if (bus.rf_wen !== m_wen) begin failures++; $display("FAIL rnd_wen c%0d got=%b exp=%b", cyc, bus.rf_wen, m_wen); end
        checks++; if (bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata) begin
          failures++; $display("FAIL rnd_port c%0d got=%h/%h exp=%h/%h", cyc, bus.rf_waddr, bus.rf_wdata, m_waddr, m_wdata); end
        checks++; if (bus.a_ready !== (a_pend.size() == 0) || bus.b_ready !== (b_pend.size() == 0)) begin
          failures++; $display("FAIL rnd_ready c%0d got=%b%b exp=%b%b", cyc, bus.a_ready, bus.b_ready, a_pend.size() == 0, b_pend.size() == 0); end
        checks++; if (bus.busy !== (a_pend.size() != 0 || b_pend.size() != 0 || m_wen)) begin
          failures++; $display("FAIL rnd_busy c%0d got=%b", cyc, bus.busy); end
      end
      // scoreboard: every DUT write must match the oldest expected write
      if (bus.rf_wen === 1'b1) begin
        got = {bus.rf_waddr, bus.rf_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_sb_unexpected c%0d got=%h", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin failures++; $display("FAIL rnd_sb c%0d got=%h exp=%h", cyc, got, e); end
        end
      end
      // new stimulus; an unaccepted request is held unchanged
      if (cyc > 2950) begin
        idle_inputs();
      end else begin
        if (!a_wait) begin
          bus.a_valid = ($urandom_range(0, 99) < 60);
          bus.a_addr  = AW'($urandom_range(0, 15));
          bus.a_data  = DW'($urandom);
        end
        if (!b_wait) begin
          bus.b_valid = ($urandom_range(0, 99) < 60);
          bus.b_addr  = AW'($urandom_range(0, 15));
          bus.b_data  = DW'($urandom);
        end
      end
      // model the coming edge
      winner = 0;
      if (a_pend.size() != 0 && b_pend.size() != 0) winner = prefer_a ? 1 : 2;
      else if (a_pend.size() != 0) winner = 1;
      else if (b_pend.size() != 0) winner = 2;
      a_acc  = bus.a_valid && (a_pend.size() == 0);
      b_acc  = bus.b_valid && (b_pend.size() == 0);
      a_wait = bus.a_valid && !a_acc;
      b_wait = bus.b_valid && !b_acc;
      m_wen  = (winner != 0);
      if (winner == 1) begin
        e = a_pend.pop_front(); prefer_a = 1'b0;
      end else if (winner == 2) begin
        e = b_pend.pop_front(); prefer_a = 1'b1;
      end
      if (winner != 0) begin
        {m_waddr, m_wdata} = e;
        exp_q.push_back(e);
      end
      if (a_acc && !(zero_drop && bus.a_addr == '0)) a_pend.push_back({bus.a_addr, bus.a_data});
      if (b_acc && !(zero_drop && bus.b_addr == '0)) b_pend.push_back({bus.b_addr, bus.b_data});
      tick();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_single_a();
    test_simultaneous();
    test_same_addr();
    test_reset_mid();
    test_zero_addr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
